// File: rtl/get_negedge.sv
// Falling-edge detector for a slow asynchronous input: synchroniser, stability filter, one-cycle pulse.
// Optional RISING_EDGE_EN adds a `rising` pulse output for filtered 0->1 transitions.
module get_negedge #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sig,
  output logic falling,
  output logic level
`ifdef RISING_EDGE_EN
  ,
  output logic rising
`endif
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("get_negedge: SYNC_STAGES must be 2 or more");
  end
  if (FILTER_LEN < 1) begin : g_bad_filt
    $error("get_negedge: FILTER_LEN must be 1 or more");
  end

  logic [SYNC_STAGES-1:0] s;
  logic                   sync_out;
  logic                   filt;
  logic [CNT_W-1:0]       cnt;

  assign sync_out = s[SYNC_STAGES-1];
  assign level    = filt;

  // NOTE: the synchroniser chain is reset to RESET_LEVEL as well, otherwise
  // stale stages could present a false transition right after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      s <= {s[SYNC_STAGES-2:0], in_sig};
    end
  end

  // A new synchronised level is accepted only after it persists FILTER_LEN edges;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt    <= RESET_LEVEL;
      cnt     <= '0;
      falling <= 1'b0;
`ifdef RISING_EDGE_EN
      rising  <= 1'b0;
`endif
    end else if (sync_out == filt) begin
      cnt     <= '0;
      falling <= 1'b0;
`ifdef RISING_EDGE_EN
      rising  <= 1'b0;
`endif
    end else if (cnt == CNT_LAST) begin
      filt    <= sync_out;
      cnt     <= '0;
      falling <= ~sync_out;
`ifdef RISING_EDGE_EN
      rising  <= sync_out;
`endif
    end else begin
      cnt     <= cnt + 1'b1;
      falling <= 1'b0;
`ifdef RISING_EDGE_EN
      rising  <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_get_negedge.sv
// Scoreboard bench for get_negedge: stimulus pushes expected pulse cycles, a monitor pops on each pulse.
// Build with RISING_EDGE_EN defined to also score the `rising` output.
module tb_get_negedge;

  localparam int LAT = 6;  // edges from the drive point to the pulse edge with defaults

  typedef struct {
    bit rise;
    int at_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_sig = 1'b1;
  logic falling;
  logic level;
`ifdef RISING_EDGE_EN
  logic rising;
`else
  logic rising = 1'b0;
`endif

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_fall = 0;
  logic prev_fall = 1'b0;
  exp_t q[$];

  get_negedge dut (
    .clk    (clk),
    .rst    (rst),
    .in_sig (in_sig),
    .falling(falling),
    .level  (level)
`ifdef RISING_EDGE_EN
    ,
    .rising (rising)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Drive in_sig right after a negedge; the following posedge is edge k.
  task automatic drive(input logic v, input bit pulse);
    in_sig = v;
    if (pulse) begin
      if (v == 1'b0) q.push_back('{rise: 1'b0, at_cyc: cyc + LAT});
`ifdef RISING_EDGE_EN
      else q.push_back('{rise: 1'b1, at_cyc: cyc + LAT});
`endif
    end
  endtask

  task automatic score(input bit is_rise);
    exp_t e;
    if (q.size() == 0) begin
      check(is_rise ? "unexpected_rising" : "unexpected_falling", 1, 0);
    end else begin
      e = q.pop_front();
      check(is_rise ? "rising_kind" : "falling_kind", int'(is_rise), int'(e.rise));
      check(is_rise ? "rising_cycle" : "falling_cycle", cyc, e.at_cyc);
    end
  endtask

  always @(negedge clk) begin
    if (falling) begin
      n_fall++;
      check("falling_back_to_back", int'(prev_fall), 0);
      check("falling_and_rising", int'(rising), 0);
      score(1'b0);
    end
    if (rising) score(1'b1);
    prev_fall = falling;
  end

  initial begin
    int f0;

    // Reset held with in_sig toggling.
    repeat (6) @(negedge clk) in_sig = ~in_sig;
    #1;
    check("reset_falling", int'(falling), 0);
    check("reset_level", int'(level), 1);
    @(negedge clk) in_sig = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_level", int'(level), 1);

    // Clean fall, then level timing around the pulse edge.
    @(negedge clk) drive(1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("fall_level_before", int'(level), 1);
    @(negedge clk);
    check("fall_level_after", int'(level), 0);
    repeat (10) @(negedge clk);
    drive(1'b1, 1'b1);
    repeat (12) @(negedge clk);
    check("rise_level", int'(level), 1);

    // Glitch of 3 cycles is rejected.
    drive(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drive(1'b1, 1'b0);
    repeat (12) @(negedge clk);
    check("glitch3_level", int'(level), 1);

    // 4 low cycles is accepted.
    drive(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    drive(1'b1, 1'b1);
    repeat (12) @(negedge clk);
    check("glitch4_level", int'(level), 1);

    // PS/2-rate burst: 11 periods of 40 low / 40 high.
    f0 = n_fall;
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b1);
      repeat (40) @(negedge clk);
      drive(1'b1, 1'b1);
      repeat (40) @(negedge clk);
    end
    check("ps2_pulse_count", n_fall - f0, 11);

    // Reset 2 cycles into filtering, released with in_sig still low.
    drive(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_falling", int'(falling), 0);
    check("midreset_level", int'(level), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.push_back('{rise: 1'b0, at_cyc: cyc + LAT});
    repeat (5) @(negedge clk);
    check("release_level_before", int'(level), 1);
    @(negedge clk);
    check("release_level_after", int'(level), 0);
    repeat (4) @(negedge clk);
    drive(1'b1, 1'b1);
    repeat (12) @(negedge clk);

    // Asynchronous reset between edges while level is low.
    drive(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("async_pre_level", int'(level), 0);
    #2 rst = 1'b1;
    #1;
    check("async_level", int'(level), 1);
    check("async_falling", int'(falling), 0);
    @(negedge clk);
    rst = 1'b0;
    q.push_back('{rise: 1'b0, at_cyc: cyc + LAT});
    repeat (10) @(negedge clk);
    drive(1'b1, 1'b1);
    repeat (15) @(negedge clk);

    check("scoreboard_drained", q.size(), 0);
    check("final_level", int'(level), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
